// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int          CPU_W    = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [CPU_W-1:0] pc;
    logic [CPU_W-1:0] inst;
  } fetch_pair_t;

  function automatic logic [CPU_W-1:0] word_addr(input logic [CPU_W-1:0] addr);
    return {addr[CPU_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo_sync.sv
// Synchronous FIFO with clear; power-of-two DEPTH, push while full is accepted only alongside a pop.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == '0);
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: issues word reads for pcIn under a credit limit, pairs returned words with their
// PCs, buffers them for decode, and drops in-flight responses after a flush.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTST  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CPU_W-1:0] pcIn,
  input  logic             flushIn,
  output logic             holdReqOut,
  output logic             imemReqOut,
  output logic [CPU_W-1:0] imemAddrOut,
  input  logic             imemGntIn,
  input  logic             imemRvalidIn,
  input  logic [CPU_W-1:0] imemRdataIn,
  output logic             instValidOut,
  output logic [CPU_W-1:0] instOut,
  output logic [CPU_W-1:0] instPcOut,
  input  logic             instReadyIn
);

  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int FW = $clog2(FIFO_DEPTH+1);

  logic [OW-1:0]    outst_r;
  logic [OW-1:0]    drop_r;
  logic [OW-1:0]    outst_nxt_s;
  logic [OW-1:0]    drop_nxt_s;
  logic [FW-1:0]    fifo_cnt_s;
  logic [OW-1:0]    pend_cnt_s;
  logic [CPU_W-1:0] pend_pc_s;
  logic [63:0]      out_rdata_s;
  fetch_pair_t      head_s;
  fetch_pair_t      push_pair_s;
  logic             can_issue_s;
  logic             grant_s;
  logic             rsp_s;
  logic             keep_s;
  logic             pop_out_s;

  assign can_issue_s = ((int'(outst_r) + int'(fifo_cnt_s)) < FIFO_DEPTH) &&
                       (int'(outst_r) < MAX_OUTST) && !flushIn && !rst;
  assign imemReqOut  = can_issue_s;
  assign imemAddrOut = word_addr(pcIn);
  assign grant_s     = imemReqOut && imemGntIn;
  assign holdReqOut  = !grant_s && !flushIn;

  // A response with nothing outstanding (e.g. one that straddled a reset) is ignored.
  assign rsp_s  = imemRvalidIn && (outst_r != '0) && !rst;
  assign keep_s = rsp_s && (drop_r == '0) && (pend_cnt_s != '0) && !flushIn;

  assign push_pair_s.pc   = pend_pc_s;
  assign push_pair_s.inst = imemRdataIn;
  assign head_s           = out_rdata_s;

  assign instValidOut = (fifo_cnt_s != '0) && !rst;
  assign instOut      = instValidOut ? head_s.inst : INST_NOP;
  assign instPcOut    = instValidOut ? head_s.pc : 32'h0000_0000;
  assign pop_out_s    = instValidOut && instReadyIn && !flushIn;

  // Outstanding/drop counter next-state; flush converts everything in flight into drops.
  always_comb begin
    outst_nxt_s = outst_r;
    drop_nxt_s  = drop_r;
    if (flushIn) begin
      outst_nxt_s = rsp_s ? (outst_r - OW'(1)) : outst_r;
      drop_nxt_s  = rsp_s ? (outst_r - OW'(1)) : outst_r;
    end else begin
      case ({grant_s, rsp_s})
        2'b10:   outst_nxt_s = outst_r + OW'(1);
        2'b01:   outst_nxt_s = outst_r - OW'(1);
        default: outst_nxt_s = outst_r;
      endcase
      if (rsp_s && (drop_r != '0)) begin
        drop_nxt_s = drop_r - OW'(1);
      end else begin
        drop_nxt_s = drop_r;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_r <= '0;
      drop_r  <= '0;
    end else begin
      outst_r <= outst_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  fifo_sync #(
    .WIDTH (CPU_W),
    .DEPTH (MAX_OUTST)
  ) u_pend_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flushIn),
    .push  (grant_s),
    .pop   (keep_s),
    .wdata (pcIn),
    .rdata (pend_pc_s),
    .count (pend_cnt_s)
  );

  fifo_sync #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flushIn),
    .push  (keep_s),
    .pop   (pop_out_s),
    .wdata (push_pair_s),
    .rdata (out_rdata_s),
    .count (fifo_cnt_s)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable in-order memory and a PC-register model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pcIn;
  logic        flushIn;
  logic        holdReqOut;
  logic        imemReqOut;
  logic [31:0] imemAddrOut;
  logic        imemGntIn;
  logic        imemRvalidIn;
  logic [31:0] imemRdataIn;
  logic        instValidOut;
  logic [31:0] instOut;
  logic [31:0] instPcOut;
  logic        instReadyIn;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       q[$];
  logic [63:0] got[$];
  int          cyc;
  int          lat;
  int          gnt_cnt;
  int          vec_cnt;
  int          err_cnt;
  bit          pc_auto;
  bit          hold_q;
  bit          fl_q;
  logic [31:0] flush_tgt;

  if_fetch_unit #(.FIFO_DEPTH(2), .MAX_OUTST(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcIn         (pcIn),
    .flushIn      (flushIn),
    .holdReqOut   (holdReqOut),
    .imemReqOut   (imemReqOut),
    .imemAddrOut  (imemAddrOut),
    .imemGntIn    (imemGntIn),
    .imemRvalidIn (imemRvalidIn),
    .imemRdataIn  (imemRdataIn),
    .instValidOut (instValidOut),
    .instOut      (instOut),
    .instPcOut    (instPcOut),
    .instReadyIn  (instReadyIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [63:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus/decoder observer: memory queue bookkeeping, grant count, delivered pairs, PC-reg snapshot.
  always @(posedge clk) begin
    if (imemRvalidIn && q.size() > 0) void'(q.pop_front());
    if (imemReqOut && imemGntIn) begin
      q.push_back('{addr: imemAddrOut, due: cyc + lat});
      gnt_cnt++;
    end
    if (!rst && !flushIn && instValidOut && instReadyIn) got.push_back({instPcOut, instOut});
    hold_q = holdReqOut;
    fl_q   = flushIn;
    cyc++;
  end

  task automatic step();
    @(negedge clk);
    if (fl_q) pcIn = flush_tgt;
    else if (pc_auto && !hold_q) pcIn = pcIn + 32'd4;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imemRvalidIn = 1'b1;
      imemRdataIn  = memfn(q[0].addr);
    end else begin
      imemRvalidIn = 1'b0;
      imemRdataIn  = 32'h0000_0000;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    imemGntIn = 1'b0; instReadyIn = 1'b1; flushIn = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(); #1;
      if (q.size() == 0 && !instValidOut && !imemRvalidIn) done = 1'b1;
    end
    check_vec("drain", 64'(done), 64'd1);
    step();
    got.delete();
    gnt_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt = 0; err_cnt = 0; cyc = 0; lat = 1; gnt_cnt = 0;
    pc_auto = 1'b0; hold_q = 1'b1; fl_q = 1'b0; flush_tgt = 32'h0;
    rst = 1'b1; pcIn = 32'h0; flushIn = 1'b0; imemGntIn = 1'b0;
    imemRvalidIn = 1'b0; imemRdataIn = 32'h0; instReadyIn = 1'b0;

    // Reset state
    repeat (3) step();
    imemGntIn = 1'b1; #1;
    check_vec("rst_req",   64'(imemReqOut),   64'd0);
    check_vec("rst_hold",  64'(holdReqOut),   64'd1);
    check_vec("rst_valid", 64'(instValidOut), 64'd0);
    check_vec("rst_inst",  64'(instOut),      64'h13);
    check_vec("rst_pc",    64'(instPcOut),    64'd0);

    // 1: streaming with 1-cycle memory
    step();
    rst = 1'b0; imemGntIn = 1'b1; instReadyIn = 1'b1; pcIn = 32'h0; pc_auto = 1'b1; lat = 1; #1;
    check_vec("t1_req0",  64'(imemReqOut),  64'd1);
    check_vec("t1_addr0", 64'(imemAddrOut), 64'h0);
    check_vec("t1_hold0", 64'(holdReqOut),  64'd0);
    step(); #1;
    check_vec("t1_val1",  64'(instValidOut), 64'd0);
    check_vec("t1_addr1", 64'(imemAddrOut),  64'h4);
    step(); #1;
    check_vec("t1_val2",  64'(instValidOut), 64'd1);
    check_vec("t1_pair2", {instPcOut, instOut}, {32'h0, 32'hC0DE_0000});
    check_vec("t1_req2",  64'(imemReqOut), 64'd0);
    check_vec("t1_hold2", 64'(holdReqOut), 64'd1);
    step(); #1;
    check_vec("t1_pair3", {instPcOut, instOut}, {32'h4, 32'hC0DE_0004});
    repeat (8) step();
    check_vec("t1_got2", got_at(2), {32'h8, 32'hC0DE_0008});
    drain();

    // 2: decode stalled from the start
    instReadyIn = 1'b0; imemGntIn = 1'b1; pcIn = 32'h40; pc_auto = 1'b1; lat = 1;
    repeat (8) step();
    #1;
    check_vec("t2_gnts",  64'(gnt_cnt),    64'd2);
    check_vec("t2_req",   64'(imemReqOut), 64'd0);
    check_vec("t2_hold",  64'(holdReqOut), 64'd1);
    check_vec("t2_head",  {instPcOut, instOut}, {32'h40, 32'hC0DE_0040});
    instReadyIn = 1'b1;
    repeat (10) step();
    check_vec("t2_got0", got_at(0), {32'h40, 32'hC0DE_0040});
    check_vec("t2_got1", got_at(1), {32'h44, 32'hC0DE_0044});
    check_vec("t2_got2", got_at(2), {32'h48, 32'hC0DE_0048});
    drain();

    // 3: grant withheld, then misaligned PC
    pc_auto = 1'b0; pcIn = 32'h100; imemGntIn = 1'b0; lat = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("t3_req",  64'(imemReqOut),  64'd1);
      check_vec("t3_addr", 64'(imemAddrOut), 64'h100);
      check_vec("t3_hold", 64'(holdReqOut),  64'd1);
      step();
    end
    imemGntIn = 1'b1; #1;
    check_vec("t3_hold_gnt", 64'(holdReqOut), 64'd0);
    step();
    pcIn = 32'h10A; #1;
    check_vec("t3_addr_mis", 64'(imemAddrOut), 64'h108);
    step();
    imemGntIn = 1'b0;
    repeat (6) step();
    check_vec("t3_got0", got_at(0), {32'h100, 32'hC0DE_0100});
    check_vec("t3_got1", got_at(1), {32'h10A, 32'hC0DE_0108});
    drain();

    // 4: flush with two reads in flight on a 3-cycle memory
    imemGntIn = 1'b1; instReadyIn = 1'b1; pcIn = 32'h20; pc_auto = 1'b1; lat = 3;
    step(); step();
    flushIn = 1'b1; flush_tgt = 32'h200; #1;
    check_vec("t4_req_fl",  64'(imemReqOut), 64'd0);
    check_vec("t4_hold_fl", 64'(holdReqOut), 64'd0);
    step();
    flushIn = 1'b0; #1;
    check_vec("t4_val_after", 64'(instValidOut), 64'd0);
    check_vec("t4_pc_after",  64'(pcIn),         64'h200);
    repeat (14) step();
    check_vec("t4_got0", got_at(0), {32'h200, 32'hC0DE_0200});
    check_vec("t4_got1", got_at(1), {32'h204, 32'hC0DE_0204});
    drain();

    // 5: flush coincident with a response, two outstanding
    imemGntIn = 1'b1; instReadyIn = 1'b1; pcIn = 32'h300; pc_auto = 1'b1; lat = 2;
    step(); step();
    flushIn = 1'b1; flush_tgt = 32'h400; #1;
    check_vec("t5_rv_fl", 64'(imemRvalidIn), 64'd1);
    step();
    flushIn = 1'b0; #1;
    check_vec("t5_val_after", 64'(instValidOut), 64'd0);
    check_vec("t5_req_after", 64'(imemReqOut),   64'd1);
    check_vec("t5_addr",      64'(imemAddrOut),  64'h400);
    repeat (10) step();
    check_vec("t5_got0", got_at(0), {32'h400, 32'hC0DE_0400});
    drain();

    // 6a: reset with the output buffer full
    instReadyIn = 1'b0; imemGntIn = 1'b1; pcIn = 32'h500; pc_auto = 1'b1; lat = 1;
    repeat (6) step();
    #1;
    check_vec("t6_full_head", {instPcOut, instOut}, {32'h500, 32'hC0DE_0500});
    rst = 1'b1; #1;
    check_vec("t6_rst_val",  64'(instValidOut), 64'd0);
    check_vec("t6_rst_inst", 64'(instOut),      64'h13);
    check_vec("t6_rst_req",  64'(imemReqOut),   64'd0);
    step();
    rst = 1'b0; imemGntIn = 1'b0; #1;
    check_vec("t6_post_val", 64'(instValidOut), 64'd0);
    check_vec("t6_post_pc",  64'(instPcOut),    64'd0);
    drain();

    // 6b: reset while reads are in flight; late responses must be ignored
    imemGntIn = 1'b1; instReadyIn = 1'b1; pcIn = 32'h600; pc_auto = 1'b1; lat = 3;
    step(); step();
    rst = 1'b1; imemGntIn = 1'b0; #1;
    check_vec("t6b_rst_req", 64'(imemReqOut), 64'd0);
    step();
    rst = 1'b0;
    step(); step(); step(); #1;
    check_vec("t6b_val",  64'(instValidOut), 64'd0);
    check_vec("t6b_req",  64'(imemReqOut),   64'd1);
    check_vec("t6b_addr", 64'(imemAddrOut),  64'h608);
    check_vec("t6b_none", 64'(got.size()),   64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
